// File: rtl/bridge_sequencer_if.sv
// Signal bundle between the I2C receive front end, the bridge sequencer and the SPI master.
// The sequencer uses the slave view; the driving environment uses the master view.
interface bridge_sequencer_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             is_addr_byte;
    logic             bus_active;
    logic             spi_start;
    logic [7:0]       spi_tx;
    logic             spi_busy;
    logic             spi_done;
    logic [3:0]       cs_n;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;
    logic             busy;

    modport slave (
        input  rx_byte, byte_valid, is_addr_byte, bus_active, spi_busy, spi_done,
        output spi_start, spi_tx, cs_n, overflow, fifo_level, busy
    );

    modport master (
        output rx_byte, byte_valid, is_addr_byte, bus_active, spi_busy, spi_done,
        input  spi_start, spi_tx, cs_n, overflow, fifo_level, busy
    );
endinterface

// File: rtl/bridge_sequencer.sv
// I2C-to-SPI bridge control: tagged byte FIFO, command-byte chip-select decode,
// and SPI frame sequencing with chip-select setup/hold timing.
module bridge_sequencer #(
    parameter int FIFO_DEPTH   = 8,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    bridge_sequencer_if.slave     bus
);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = AW + 1;
    localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cs_sel_q, cs_sel_d;
    logic [7:0]       tx_q, tx_d;
    logic             start_q, start_d;
    logic [3:0]       cs_n_q, cs_n_d;
    logic             busy_q, busy_d;

    logic             empty_s, full_s, push_s, pop_s, head_cmd_s;
    logic [8:0]       head_s;

    assign empty_s    = (level_q == LVL_W'(0));
    assign full_s     = (level_q == LVL_W'(FIFO_DEPTH));
    assign head_s     = mem_q[rd_ptr_q];
    assign head_cmd_s = head_s[8];
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign push_s     = bus.byte_valid && (!full_s || pop_s);

    // FIFO storage; entries are {is_cmd, byte}.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.is_addr_byte, bus.rx_byte};
        end
    end

    // Occupancy and sticky overflow next-state; a dropped push wins over a command clear.
    always_comb begin
        level_d    = level_q;
        overflow_d = overflow_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (bus.byte_valid && !push_s) begin
            overflow_d = 1'b1;
        end else if (bus.byte_valid && bus.is_addr_byte) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Frame sequencer next-state and output decisions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cs_sel_d = cs_sel_q;
        tx_d     = tx_q;
        start_d  = 1'b0;
        pop_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    if (head_cmd_s) begin
                        pop_s    = 1'b1;
                        cs_sel_d = head_s[1:0];
                    end else begin
                        cs_sel_d = cs_sel_q;
                    end
                    cnt_d   = CNT_W'(0);
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) begin
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ISSUE: begin
                if (!empty_s && head_cmd_s) begin
                    cnt_d   = CNT_W'(0);
                    state_d = ST_HOLD;
                end else if (!empty_s && !bus.spi_busy) begin
                    pop_s   = 1'b1;
                    tx_d    = head_s[7:0];
                    start_d = 1'b1;
                    state_d = ST_WAIT;
                end else if (empty_s && !bus.bus_active) begin
                    cnt_d   = CNT_W'(0);
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.spi_done) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD_CYC - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered chip-select and busy follow the state being entered.
    always_comb begin
        cs_n_d = 4'hF;
        case (state_d)
            ST_SETUP, ST_ISSUE, ST_WAIT, ST_HOLD: cs_n_d = ~(4'b0001 << cs_sel_d);
            default:                             cs_n_d = 4'hF;
        endcase
        busy_d = (state_d != ST_IDLE) || (level_d != LVL_W'(0));
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= AW'(0);
            rd_ptr_q   <= AW'(0);
            level_q    <= LVL_W'(0);
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_W'(0);
            cs_sel_q   <= 2'd0;
            tx_q       <= 8'h00;
            start_q    <= 1'b0;
            cs_n_q     <= 4'hF;
            busy_q     <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_sel_q   <= cs_sel_d;
            tx_q       <= tx_d;
            start_q    <= start_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.spi_start  = start_q;
    assign bus.spi_tx     = tx_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = level_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_bridge_sequencer.sv
// Self-checking bench for bridge_sequencer: frame table, SPI model with a
// {cs_n, byte} scoreboard, and hand-written corner-case sequences.
module tb_bridge_sequencer;
    localparam int DEPTH = 8;
    localparam int SETUP = 4;
    localparam int HOLD  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bridge_sequencer_if #(.FIFO_DEPTH(DEPTH)) bif ();

    bridge_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .CS_SETUP_CYC(SETUP),
        .CS_HOLD_CYC (HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic busy_m = 1'b0, done_m = 1'b0, hold_busy = 1'b0, done_f = 1'b0, model_en = 1'b1;
    int   xfer_len = 3;
    int   mcnt = 0;
    int   starts = 0;
    logic [7:0]  cur_tx = 8'h00;
    logic [11:0] exp_q[$];
    logic [11:0] e;

    assign bif.spi_busy = busy_m | hold_busy;
    assign bif.spi_done = done_m | done_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI master model: fixed-length transfers, scoreboard pop on each spi_start.
    always @(negedge clk) begin
        done_m = 1'b0;
        if (!model_en) begin
            busy_m = 1'b0;
            mcnt   = 0;
        end else if (bif.spi_start) begin
            check("start_while_busy", 32'(bif.spi_busy), 32'd0);
            starts++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_start: got tx %02h cs_n %b, none expected", bif.spi_tx, bif.cs_n);
            end else begin
                e = exp_q.pop_front();
                check("start_cs_tx", 32'({bif.cs_n, bif.spi_tx}), 32'(e));
            end
            busy_m = 1'b1;
            mcnt   = xfer_len;
            cur_tx = bif.spi_tx;
        end else if (busy_m) begin
            check("tx_stable", 32'(bif.spi_tx), 32'(cur_tx));
            mcnt--;
            if (mcnt == 0) begin
                busy_m = 1'b0;
                done_m = 1'b1;
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic c);
        @(negedge clk);
        bif.rx_byte      = b;
        bif.is_addr_byte = c;
        bif.byte_valid   = 1'b1;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bif.byte_valid   = 1'b0;
        bif.is_addr_byte = 1'b0;
    endtask

    task automatic wait_quiet(input string name, input int bound);
        int n;
        n = 0;
        while (n < bound && !(!bif.busy && bif.cs_n == 4'hF)) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < bound), 32'd1);
    endtask

    typedef struct {
        logic [7:0] cmd;
        int         n;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] cs;
    } frame_t;

    frame_t     tbl[5];
    int         low, bad, s0, lat, t, gap, direct;
    bit         fin;
    logic [3:0] prev, cur;
    logic [3:0] fr[$];

    initial begin
        tbl[0] = '{cmd: 8'h01, n: 2, d0: 8'hA5, d1: 8'h3C, cs: 4'b1101};
        tbl[1] = '{cmd: 8'h01, n: 0, d0: 8'h00, d1: 8'h00, cs: 4'b1101};
        tbl[2] = '{cmd: 8'hFE, n: 1, d0: 8'h5A, d1: 8'h00, cs: 4'b1011};
        tbl[3] = '{cmd: 8'h00, n: 2, d0: 8'h00, d1: 8'hFF, cs: 4'b1110};
        tbl[4] = '{cmd: 8'h03, n: 1, d0: 8'hC3, d1: 8'h00, cs: 4'b0111};

        bif.rx_byte = 8'h00; bif.byte_valid = 1'b0; bif.is_addr_byte = 1'b0; bif.bus_active = 1'b0;
        rst = 1'b1;
        #12;
        check("rst_cs_n",      32'(bif.cs_n),       32'hF);
        check("rst_spi_start", 32'(bif.spi_start),  32'd0);
        check("rst_spi_tx",    32'(bif.spi_tx),     32'd0);
        check("rst_overflow",  32'(bif.overflow),   32'd0);
        check("rst_level",     32'(bif.fifo_level), 32'd0);
        check("rst_busy",      32'(bif.busy),       32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of single frames: command, up to two data bytes, then STOP.
        for (int k = 0; k < 5; k++) begin
            low = 0; bad = 0; s0 = starts; xfer_len = 3;
            fork
                begin
                    bif.bus_active = 1'b1;
                    drive(tbl[k].cmd, 1'b1);
                    if (tbl[k].n > 0) begin
                        exp_q.push_back({tbl[k].cs, tbl[k].d0});
                        drive(tbl[k].d0, 1'b0);
                    end
                    if (tbl[k].n > 1) begin
                        exp_q.push_back({tbl[k].cs, tbl[k].d1});
                        drive(tbl[k].d1, 1'b0);
                    end
                    drive_idle();
                    bif.bus_active = 1'b0;
                end
                begin
                    t = 0; fin = 1'b0;
                    while (!fin && t < 1000) begin
                        @(negedge clk);
                        t++;
                        if (bif.cs_n == tbl[k].cs) low++;
                        else if (bif.cs_n != 4'hF) bad++;
                        else if (low > 0 && !bif.busy) fin = 1'b1;
                    end
                    check("frame_timeout", 32'(fin), 32'd1);
                end
            join
            check("frame_cs_low_cycles", 32'(low), 32'(SETUP + tbl[k].n * (3 + 2) + 1 + HOLD));
            check("frame_bad_cs",        32'(bad), 32'd0);
            check("frame_starts",        32'(starts - s0), 32'(tbl[k].n));
            check("frame_sb_empty",      32'(exp_q.size()), 32'd0);
            check("frame_overflow",      32'(bif.overflow), 32'd0);
            check("frame_level",         32'(bif.fifo_level), 32'd0);
        end

        // Lone data byte from IDLE with empty FIFO: reuses the last cs_sel.
        s0 = starts;
        exp_q.push_back({4'b0111, 8'h77});
        @(negedge clk);
        bif.rx_byte = 8'h77; bif.is_addr_byte = 1'b0; bif.byte_valid = 1'b1;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            bif.byte_valid = 1'b0;
            lat++;
            if (bif.spi_start) break;
        end
        check("first_start_latency", 32'(lat - 1), 32'(2 + SETUP));
        wait_quiet("lone_drain", 200);
        check("lone_starts", 32'(starts - s0), 32'd1);

        // Two frames queued back-to-back across a repeated START.
        s0 = starts; prev = 4'hF; gap = 0; direct = 0; fr.delete();
        exp_q.push_back({4'b1011, 8'h11});
        exp_q.push_back({4'b0111, 8'h22});
        fork
            begin
                bif.bus_active = 1'b1;
                drive(8'h02, 1'b1);
                drive(8'h11, 1'b0);
                drive(8'h03, 1'b1);
                drive(8'h22, 1'b0);
                drive_idle();
                bif.bus_active = 1'b0;
            end
            begin
                t = 0; fin = 1'b0;
                while (!fin && t < 1000) begin
                    @(negedge clk);
                    t++;
                    cur = bif.cs_n;
                    if (cur != 4'hF && prev == 4'hF) fr.push_back(cur);
                    if (cur != 4'hF && prev != 4'hF && cur != prev) direct++;
                    if (fr.size() > 0 && cur == 4'hF && !bif.busy) fin = 1'b1;
                    prev = cur;
                end
                check("rs_timeout", 32'(fin), 32'd1);
            end
        join
        check("rs_frame_count", 32'(fr.size()), 32'd2);
        if (fr.size() == 2) begin
            check("rs_frame1_cs", 32'(fr[0]), 32'(4'b1011));
            check("rs_frame2_cs", 32'(fr[1]), 32'(4'b0111));
        end
        check("rs_no_direct_cs_switch", 32'(direct), 32'd0);
        check("rs_starts", 32'(starts - s0), 32'd2);

        // Overflow: master held busy, command plus nine data bytes back-to-back.
        s0 = starts; xfer_len = 20; hold_busy = 1'b1;
        for (int i = 1; i <= 8; i++) exp_q.push_back({4'b1110, 8'(8'h80 + i)});
        bif.bus_active = 1'b1;
        drive(8'h00, 1'b1);
        for (int i = 1; i <= 9; i++) drive(8'(8'h80 + i), 1'b0);
        drive_idle();
        check("ovf_set",        32'(bif.overflow),   32'd1);
        check("ovf_level_peak", 32'(bif.fifo_level), 32'd8);
        drive(8'h02, 1'b1);
        drive_idle();
        check("ovf_cmd_drop_set_wins", 32'(bif.overflow),   32'd1);
        check("ovf_level_still_full",  32'(bif.fifo_level), 32'd8);
        hold_busy = 1'b0;
        bif.bus_active = 1'b0;
        wait_quiet("ovf_drain", 2000);
        check("ovf_starts",   32'(starts - s0), 32'd8);
        check("ovf_sb_empty", 32'(exp_q.size()), 32'd0);
        check("ovf_sticky",   32'(bif.overflow), 32'd1);
        drive(8'h00, 1'b1);
        drive_idle();
        check("ovf_cleared_by_cmd", 32'(bif.overflow), 32'd0);
        wait_quiet("ovf_cmd_frame", 200);

        // Long gap with bus_active held: CS must stay asserted throughout.
        s0 = starts; xfer_len = 3; bad = 0;
        exp_q.push_back({4'b1101, 8'h10});
        exp_q.push_back({4'b1101, 8'h20});
        bif.bus_active = 1'b1;
        drive(8'h01, 1'b1);
        drive(8'h10, 1'b0);
        drive_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bif.cs_n != 4'b1101) bad++;
        end
        check("gap_cs_held", 32'(bad), 32'd0);
        drive(8'h20, 1'b0);
        drive_idle();
        bif.bus_active = 1'b0;
        wait_quiet("gap_drain", 200);
        check("gap_starts", 32'(starts - s0), 32'd2);
        check("gap_cs_released", 32'(bif.cs_n), 32'hF);

        // Asynchronous reset while a transfer is in flight.
        s0 = starts; xfer_len = 20;
        exp_q.push_back({4'b1011, 8'h99});
        bif.bus_active = 1'b1;
        drive(8'h02, 1'b1);
        drive(8'h99, 1'b0);
        drive_idle();
        t = 0;
        while (starts == s0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rstw_start_seen", 32'(starts - s0), 32'd1);
        drive(8'h55, 1'b0);
        drive_idle();
        repeat (2) @(negedge clk);
        model_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rstw_cs_n",      32'(bif.cs_n),       32'hF);
        check("rstw_spi_start", 32'(bif.spi_start),  32'd0);
        check("rstw_spi_tx",    32'(bif.spi_tx),     32'd0);
        check("rstw_level",     32'(bif.fifo_level), 32'd0);
        check("rstw_busy",      32'(bif.busy),       32'd0);
        check("rstw_overflow",  32'(bif.overflow),   32'd0);
        bif.bus_active = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        done_f = 1'b1;
        @(negedge clk);
        done_f = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bif.spi_start || bif.cs_n != 4'hF || bif.busy) bad++;
        end
        check("rstw_spurious_done_ignored", 32'(bad), 32'd0);
        check("rstw_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
